chan_scan_mux: RTL and testbench
================================

# chan_scan_mux

Parametrised, registered N-channel, W-bit multiplexer for the board-level switch/LED datapath. It selects one of N packed input channels either from a manual select word or by automatically scanning through all channels with a programmable dwell time. Output data, channel index and a change strobe are registered on the board clock. It feeds LED/7-segment display logic.

## Interface
- N, 5: number of input channels; must be ≥ 1.
- W, 3: bits per channel; must be ≥ 1.
- DWELL, 50_000_000: clock cycles spent on each channel in scan mode; must be ≥ 1.
- SELW, derived: max(1, clog2(N)). This is a localparam, not user-set.
- CLOCK_50  in  1  single clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- data_in  in  N*W  packed channels; channel k occupies data_in[k*W +: W].
- sel  in  SELW  manual channel select.
- mode  in  1  0 = manual, 1 = auto-scan.
- hold  in  1  freezes all state while high.
- data_out  out  W  registered selected channel data.
- chan_out  out  SELW  registered index of the selected channel.
- chan_strobe  out  1  one-cycle pulse when chan_out changes value.

## Operation
- State: cur (SELW bits), dwell counter cnt (clog2(DWELL) bits, minimum 1), plus the output registers.
- Clamp rule: eff_sel = (sel ≥ N) ? N-1 : sel.
- Priority on each edge is hold > mode.
- hold=1: cur, cnt, data_out and chan_out keep their values; chan_strobe is forced to 0.
- mode=0 (manual): next = eff_sel; cnt is cleared to 0.
- mode=1 (scan):
  - If cnt == DWELL-1: next = (cur == N-1) ? 0 : cur+1, and cnt clears to 0.
  - Otherwise: next = cur, and cnt increments.
- Entering scan starts from the current cur with cnt = 0, so the first dwell is a full DWELL cycles.
- Register updates (when not in hold): cur ← next; chan_out ← next; data_out ← data_in[next*W +: W]; chan_strobe ← (next != cur).
- data_out follows live changes of the selected channel's data every cycle. A data change alone produces no strobe.
- N=1: the sel input is ignored, cur stays 0 and chan_strobe never asserts.
- DWELL=1: the index advances every cycle and chan_strobe stays high continuously (when N > 1).

## Timing
- Reset (asynchronous, immediate): cur=0, cnt=0, data_out=0, chan_out=0, chan_strobe=0.
- First edge after RESET falls (hold=0): data_out = channel 0 in scan mode, or channel eff_sel in manual mode.
- Latency is 1 cycle. sel, mode and data_in sampled at edge k appear on data_out and chan_out after edge k.
- data_out and chan_out always describe the same channel in the same cycle.
- chan_strobe is high in exactly the cycle in which chan_out first shows the new index.
- Scan cadence: each index is shown for exactly DWELL cycles; a full rotation takes N*DWELL cycles.
- Releasing hold resumes with the frozen cnt; no cycles are lost or repeated.
- RESET asserted mid-dwell: all state is cleared; scanning restarts at channel 0.
- Switching mode 1→0 mid-dwell: the next edge loads eff_sel and strobes only if eff_sel differs from cur.

## Structure
- Shared package chan_mux_pkg holds:
  - the mode constants MODE_MANUAL=1'b0 and MODE_SCAN=1'b1;
  - a clog2-based width function used for SELW and the counter width.
- One sub-module, scan_index_ctr, holds cnt and the wrap-around next-index logic (inputs: enable, clear, cur; output: next).
- The top level holds the clamp, the selection mux and the output registers.

## Test plan
All cases use N=5, W=3, DWELL=4, with data_in channels 0..4 = 1,2,3,4,5.
- Reset: assert RESET during scan with chan_out=2 → outputs go to 0 before the next edge. Release with mode=1 → the first edge gives data_out=1, chan_out=0.
- Manual select: mode=0, sel 0→3 → after one edge data_out=4, chan_out=3, chan_strobe high for 1 cycle; holding sel=3 gives no further strobes.
- Clamp: sel=6 → chan_out=4, data_out=5. Then sel=7 → no strobe, because the index is unchanged.
- Scan with wrap: mode=1 starting at cur=3 → chan_out shows 3 for 4 cycles, then 4 for 4 cycles, then 0. A strobe occurs at each change; a full rotation takes 20 cycles.
- Hold: assert hold for 10 cycles after 2 cycles on channel 1 → all outputs frozen and no strobe. After release, channel 1 is shown for 2 more cycles, then the index moves to 2.
- Live data: scan dwelling on channel 2, change channel 2's data 3→6 → data_out=6 one edge later, chan_strobe stays 0.

Source files
------------

// File: rtl/chan_mux_pkg.sv
// chan_mux_pkg: shared mode constants and width helper for the channel scan mux
package chan_mux_pkg;
  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN = 1'b1;
  function automatic int clog2w(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/scan_index_ctr.sv
// scan_index_ctr: dwell counter and wrap-around next-index for auto-scan
module scan_index_ctr import chan_mux_pkg::*; #(
  parameter int N = 5,
  parameter int DWELL = 4,
  parameter int SELW = 3,
  localparam int CW = clog2w(DWELL)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            clr,
  input  logic [SELW-1:0] cur,
  output logic [SELW-1:0] next
);
  localparam logic [CW-1:0] CLAST = CW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);
  logic [CW-1:0] cnt;
  logic done;
  assign done = cnt == CLAST;
  assign next = !done ? cur : (cur == LAST) ? '0 : cur + 1'b1;
  // count dwell cycles while scanning; clear on manual or at end of dwell
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (clr || (en && done)) cnt <= '0;
    else if (en) cnt <= cnt + 1'b1;
endmodule

// File: rtl/chan_scan_mux.sv
// chan_scan_mux: registered N-channel mux with manual select and timed auto-scan
module chan_scan_mux import chan_mux_pkg::*; #(
  parameter int N = 5,
  parameter int W = 3,
  parameter int DWELL = 50_000_000,
  localparam int SELW = clog2w(N)
) (
  input  logic            CLOCK_50,
  input  logic            RESET,
  input  logic [N*W-1:0]  data_in,
  input  logic [SELW-1:0] sel,
  input  logic            mode,
  input  logic            hold,
  output logic [W-1:0]    data_out,
  output logic [SELW-1:0] chan_out,
  output logic            chan_strobe
);
  localparam logic [SELW:0] NCH = (SELW + 1)'(N);
  localparam logic [SELW-1:0] LAST = SELW'(N - 1);
  logic [SELW-1:0] cur, eff_sel, scan_next, next;
  assign eff_sel = ({1'b0, sel} >= NCH) ? LAST : sel;
  assign next = (mode == MODE_SCAN) ? scan_next : eff_sel;
  assign chan_out = cur;
  scan_index_ctr #(.N(N), .DWELL(DWELL), .SELW(SELW)) u_ctr (
    .clk(CLOCK_50),
    .rst(RESET),
    .en(!hold && mode == MODE_SCAN),
    .clr(!hold && mode == MODE_MANUAL),
    .cur(cur),
    .next(scan_next)
  );
  // index, data and change strobe all register from the same next index
  always_ff @(posedge CLOCK_50 or posedge RESET)
    if (RESET) begin
      cur <= '0;
      data_out <= '0;
      chan_strobe <= 1'b0;
    end else if (hold) chan_strobe <= 1'b0;
    else begin
      cur <= next;
      data_out <= data_in[next*W +: W];
      chan_strobe <= next != cur;
    end
endmodule

// File: tb/tb_chan_scan_mux.sv
// tb_chan_scan_mux: table, directed and randomized checks against a scan model
module tb_chan_scan_mux;
  localparam int N = 5, W = 3, DWELL = 4, SELW = 3;
  logic CLOCK_50 = 1'b0, RESET = 1'b0;
  logic [N*W-1:0] data_in;
  logic [SELW-1:0] sel;
  logic mode, hold;
  logic [W-1:0] data_out;
  logic [SELW-1:0] chan_out;
  logic chan_strobe;
  int checks = 0, failures = 0;
  int m_idx, m_base, m_s, m_data;
  logic m_stb;
  int strobes;
  typedef struct {int sel; logic mode; logic hold; int chan; int data; logic stb;} vec_t;
  vec_t vecs[8];

  chan_scan_mux #(.N(N), .W(W), .DWELL(DWELL)) dut (
    .CLOCK_50(CLOCK_50), .RESET(RESET), .data_in(data_in), .sel(sel),
    .mode(mode), .hold(hold), .data_out(data_out), .chan_out(chan_out),
    .chan_strobe(chan_strobe)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic cmp(string nm, int got, int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic model_reset();
    m_idx = 0; m_base = 0; m_s = 0; m_data = 0; m_stb = 1'b0;
  endtask

  // scan position is base + elapsed scan edges / DWELL, modulo N
  task automatic model_edge();
    int nxt;
    if (hold) begin
      m_stb = 1'b0;
      return;
    end
    if (!mode) begin
      nxt = (int'(sel) >= N) ? N - 1 : int'(sel);
      m_base = nxt;
      m_s = 0;
    end else begin
      m_s++;
      nxt = (m_base + m_s / DWELL) % N;
    end
    m_stb = nxt != m_idx;
    m_idx = nxt;
    m_data = int'(data_in[nxt*W +: W]);
  endtask

  task automatic chk_model(string nm);
    cmp({nm, " data_out"}, int'(data_out), m_data);
    cmp({nm, " chan_out"}, int'(chan_out), m_idx);
    cmp({nm, " chan_strobe"}, int'(chan_strobe), int'(m_stb));
  endtask

  task automatic tick(string nm);
    model_edge();
    @(posedge CLOCK_50);
    #1;
    chk_model(nm);
  endtask

  task automatic do_reset();
    #2 RESET = 1'b1;
    #1;
    model_reset();
    chk_model("reset");
    RESET = 1'b0;
  endtask

  initial begin
    data_in = {3'd5, 3'd4, 3'd3, 3'd2, 3'd1};
    sel = '0; mode = 1'b0; hold = 1'b0;
    model_reset();
    do_reset();
    vecs[0] = '{0, 1'b0, 1'b0, 0, 1, 1'b0};
    vecs[1] = '{3, 1'b0, 1'b0, 3, 4, 1'b1};
    vecs[2] = '{3, 1'b0, 1'b0, 3, 4, 1'b0};
    vecs[3] = '{6, 1'b0, 1'b0, 4, 5, 1'b1};
    vecs[4] = '{7, 1'b0, 1'b0, 4, 5, 1'b0};
    vecs[5] = '{1, 1'b0, 1'b0, 1, 2, 1'b1};
    vecs[6] = '{2, 1'b0, 1'b1, 1, 2, 1'b0};
    vecs[7] = '{2, 1'b0, 1'b0, 2, 3, 1'b1};
    for (int i = 0; i < 8; i++) begin
      sel = SELW'(vecs[i].sel); mode = vecs[i].mode; hold = vecs[i].hold;
      tick("vec");
      cmp($sformatf("vec%0d chan", i), int'(chan_out), vecs[i].chan);
      cmp($sformatf("vec%0d data", i), int'(data_out), vecs[i].data);
      cmp($sformatf("vec%0d stb", i), int'(chan_strobe), int'(vecs[i].stb));
    end
    hold = 1'b0;
    do_reset();
    mode = 1'b1;
    repeat (8) tick("scan_to_2");
    cmp("scan reached 2", int'(chan_out), 2);
    do_reset();
    cmp("async reset chan", int'(chan_out), 0);
    tick("post_reset");
    cmp("post reset data", int'(data_out), 1);
    cmp("post reset chan", int'(chan_out), 0);
    mode = 1'b0; sel = 3'd3;
    tick("preload3");
    mode = 1'b1;
    strobes = 0;
    for (int i = 1; i <= 20; i++) begin
      tick("wrap");
      if (chan_strobe) strobes++;
      if (i == 3) cmp("wrap still 3", int'(chan_out), 3);
      if (i == 4) cmp("wrap to 4", int'(chan_out), 4);
      if (i == 8) cmp("wrap to 0", int'(chan_out), 0);
    end
    cmp("rotation strobes", strobes, 5);
    cmp("rotation end chan", int'(chan_out), 3);
    do_reset();
    mode = 1'b1;
    repeat (5) tick("to_ch1");
    cmp("hold start chan", int'(chan_out), 1);
    hold = 1'b1;
    repeat (10) tick("hold");
    cmp("held chan", int'(chan_out), 1);
    cmp("held stb", int'(chan_strobe), 0);
    hold = 1'b0;
    tick("resume1");
    cmp("resume1 chan", int'(chan_out), 1);
    tick("resume2");
    cmp("resume2 chan", int'(chan_out), 1);
    tick("resume3");
    cmp("resume3 chan", int'(chan_out), 2);
    cmp("resume3 stb", int'(chan_strobe), 1);
    data_in[2*W +: W] = 3'd6;
    tick("live");
    cmp("live data", int'(data_out), 6);
    cmp("live stb", int'(chan_strobe), 0);
    for (int i = 0; i < 400; i++) begin
      data_in = N*W'($urandom);
      sel = SELW'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) mode = ~mode;
      hold = $urandom_range(0, 7) == 0;
      if ($urandom_range(0, 63) == 0) do_reset();
      tick("rand");
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
